// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared I/O bus types and lane helpers.
// Used by the bridge and by the CPU load/store unit.
package io_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WAIT  = 3'd2,
    XFER  = 3'd3,
    RESP  = 3'd4
  } io_state_e;

  localparam logic [31:0] IO_BASE = 32'h8000_0000;

  // Expand byte enables into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(
    input logic [3:0] be
  );
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Lane-aligned CPU data to LSB-aligned bus data.
  function automatic logic [31:0] store_align(
    input logic [31:0] wdata,
    input logic [3:0]  be,
    input logic [1:0]  lane
  );
    return (wdata & lane_mask(be)) >> {lane, 3'b000};
  endfunction

  // LSB-aligned bus data to lane-aligned CPU data.
  function automatic logic [31:0] load_align(
    input logic [31:0] rdata,
    input logic [3:0]  be,
    input logic [1:0]  lane
  );
    return (rdata << {lane, 3'b000}) & lane_mask(be);
  endfunction

  // Window hit, first enabled byte sits exactly on the lane.
  function automatic logic access_legal(
    input logic [31:0] addr,
    input logic [3:0]  be,
    input logic [31:0] base
  );
    logic [3:0] below;
    below = (4'd1 << addr[1:0]) - 4'd1;
    return (addr[31:8] == base[31:8]) &&
           (be != 4'd0) &&
           be[addr[1:0]] &&
           ((be & below) == 4'd0);
  endfunction

endpackage

// File: rtl/io_bus_bridge.sv
// io_bus_bridge: CPU data requests to 8-bit I/O bus.
// Lane alignment, wait states, error on bad access.
module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter logic [31:0] BASE        = IO_BASE,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_be,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [7:0]  io_addr,
  output logic        io_en,
  output logic        io_we,
  output logic [31:0] io_data_write,
  input  logic [31:0] io_data_read
);

  localparam logic [3:0] WAIT_LAST =
    4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  io_state_e  state;
  logic [3:0] cnt;
  logic       we_q;
  logic [1:0] lane_q;
  logic [3:0] be_q;
  logic       legal;

  assign legal = access_legal(cpu_addr, cpu_be, BASE);

  // Access sequencer; all outputs registered.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state         <= IDLE;
      cnt           <= '0;
      we_q          <= 1'b0;
      lane_q        <= '0;
      be_q          <= '0;
      cpu_ready     <= 1'b0;
      cpu_err       <= 1'b0;
      cpu_rdata     <= '0;
      io_en         <= 1'b0;
      io_we         <= 1'b0;
      io_addr       <= '0;
      io_data_write <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            if (legal) begin
              we_q          <= cpu_we;
              lane_q        <= cpu_addr[1:0];
              be_q          <= cpu_be;
              io_addr       <= cpu_addr[7:0];
              io_data_write <= store_align(
                cpu_wdata, cpu_be, cpu_addr[1:0]);
              io_en         <= 1'b1;
              state         <= SETUP;
            end else begin
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          cnt <= '0;
          if (WAIT_CYCLES != 0) begin
            state <= WAIT;
          end else begin
            io_we <= we_q;
            state <= XFER;
          end
        end
        WAIT: begin
          if (cnt == WAIT_LAST) begin
            io_we <= we_q;
            state <= XFER;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        XFER: begin
          io_en     <= 1'b0;
          io_we     <= 1'b0;
          cpu_ready <= 1'b1;
          cpu_err   <= 1'b0;
          if (we_q) begin
            cpu_rdata <= '0;
          end else begin
            cpu_rdata <= load_align(
              io_data_read, be_q, lane_q);
          end
          state <= RESP;
        end
        RESP: begin
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          cpu_rdata <= '0;
          state     <= IDLE;
        end
        default: begin
          io_en     <= 1'b0;
          io_we     <= 1'b0;
          cpu_ready <= 1'b0;
          cpu_err   <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Upstream feeder of the I/O port block: converts CPU data-memory requests in the I/O window (BASE..BASE+0xFF) into single-cycle io_en/io_we strobes on the 8-bit-addressed I/O bus.
- Performs byte-lane alignment: the I/O side is LSB-aligned, the CPU side is lane-aligned.
- Inserts programmable wait states.
- Flags out-of-window and lane-overflowing accesses with cpu_err instead of touching the bus.

Parameters:
- BASE, 32'h8000_0000, I/O window base; only bits [31:8] are compared.
- WAIT_CYCLES, 0, extra cycles io_en is held before read data is sampled (0..15).

Ports:
- clk  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- cpu_req  in  1  request valid; held with all request fields stable until cpu_ready
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address
- cpu_be  in  4  byte enables, lane-aligned (contiguous: 0001,0010,0100,1000,0011,1100,1111)
- cpu_wdata  in  32  lane-aligned store data
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  lane-aligned load data, valid while cpu_ready=1
- cpu_err  out  1  qualifies cpu_ready: access rejected
- io_addr  out  8  I/O register address
- io_en  out  1  I/O access active
- io_we  out  1  I/O write strobe, one cycle
- io_data_write  out  32  LSB-aligned write data
- io_data_read  in  32  LSB-aligned read data, combinational from the I/O block

Behaviour:
- Reset (async, resetb=0): state=IDLE; cpu_ready=0, cpu_err=0, cpu_rdata=0, io_en=0, io_we=0, io_addr=0, io_data_write=0. Asserting reset mid-access aborts it with no io_we and no cpu_ready.
- lane = cpu_addr[1:0].
- Access is legal iff:
  - cpu_addr[31:8]==BASE[31:8];
  - cpu_be != 0;
  - (cpu_be >> lane) has bit 0 set;
  - no enabled byte lies below lane.
- FSM states: IDLE, SETUP, WAIT, XFER, RESP.
- IDLE:
  - cpu_req=1 and legal: latch addr/we/wdata. io_data_write = cpu_wdata >> (8*lane), masked to the enabled bytes, with upper bytes 0. Go to SETUP.
  - cpu_req=1 and illegal: go to RESP with err=1.
- SETUP: io_addr=latched cpu_addr[7:0], io_en=1. Go to WAIT if WAIT_CYCLES>0, else XFER.
- WAIT: io_en=1; 4-bit counter counts WAIT_CYCLES cycles, then go to XFER.
- XFER:
  - io_en=1; io_we=latched we (exactly one cycle).
  - On loads, register cpu_rdata = (io_data_read << 8*lane), masked to enabled lanes, other bits 0.
  - Go to RESP.
- RESP:
  - cpu_ready=1 for one cycle; cpu_err per decode.
  - On error: cpu_rdata=0 and no io_en/io_we was ever driven.
  - Return to IDLE. The next request is accepted no earlier than the following cycle.
- Timing:
  - Legal latency from request acceptance to cpu_ready: 3+WAIT_CYCLES cycles.
  - Illegal latency: 1 cycle.
- io_addr and io_data_write hold their value outside active states (no glitch to 0). io_en=0 in IDLE and RESP.
- cpu_req dropped before cpu_ready is a protocol violation; the bridge completes the latched access regardless.
- A store never issues a preceding read (no read-modify-write). Sub-word stores rely on the I/O block's byte-addressed registers.

Decomposition:
- Shared package io_bus_pkg:
  - state encoding (IDLE=0..RESP=4);
  - IO_BASE constant;
  - lane shift/mask helper functions, reused by the CPU load/store unit.
- No sub-module; the alignment logic is a function, not an instance.

Test Plan:
- Byte store 0x55 to 0x8000_0001 (be=0010, wdata=0x0000_5500):
  - one io_we pulse with io_addr=0x01, io_data_write=0x0000_0055;
  - cpu_ready 3 cycles after acceptance, cpu_err=0.
- Word load from 0x8000_0010 with io_data_read=0xDEAD_BEEF, WAIT_CYCLES=2:
  - io_en high 4 cycles, io_we=0;
  - cpu_rdata=0xDEAD_BEEF with cpu_ready 5 cycles after acceptance.
- Byte load from 0x8000_0002 (be=0100) with io_data_read=0x0000_00A5:
  - cpu_rdata=0x00A5_0000.
- Store to 0x9000_0000:
  - cpu_ready+cpu_err next cycle;
  - io_en and io_we never asserted; cpu_rdata=0.
- be=0110 at lane 0 (enabled byte misaligned to address):
  - cpu_err=1, no bus activity.
- resetb pulled low during WAIT of a store:
  - all outputs 0 immediately, no io_we issued;
  - after release, a new load completes normally.
